// File: rtl/barrido_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner.
//
// Contents:
//   scan_state_t  - scanner FSM states (BLANK dead time, ON digit slot)
//   SEG_OFF       - all segments dark, active-high encoding
//   SEG_0..SEG_F  - hex glyphs, bit order {g,f,e,d,c,b,a}, active-high
//   PWM_PERIOD    - length of the free-running brightness counter cycle
package barrido_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_A   = 7'h77;
  localparam logic [6:0] SEG_B   = 7'h7C;
  localparam logic [6:0] SEG_C   = 7'h39;
  localparam logic [6:0] SEG_D   = 7'h5E;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_F   = 7'h71;

  // Brightness counter runs 0..PWM_PERIOD-1, so level 15 means always lit.
  localparam int PWM_PERIOD = 15;

endpackage

// File: rtl/module_hex_to_7seg.sv
// Combinational hex-to-seven-segment decoder.
//
// Ports:
//   code_i  in  4  hex digit 0..F
//   seg_o   out 7  segments {g,f,e,d,c,b,a}, active-high
module module_hex_to_7seg
  import barrido_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  // Plain lookup of the sixteen hex glyphs; polarity is handled by the caller.
  always_comb begin
    seg_o = SEG_OFF;
    unique case (code_i)
      4'h0: seg_o = SEG_0;
      4'h1: seg_o = SEG_1;
      4'h2: seg_o = SEG_2;
      4'h3: seg_o = SEG_3;
      4'h4: seg_o = SEG_4;
      4'h5: seg_o = SEG_5;
      4'h6: seg_o = SEG_6;
      4'h7: seg_o = SEG_7;
      4'h8: seg_o = SEG_8;
      4'h9: seg_o = SEG_9;
      4'hA: seg_o = SEG_A;
      4'hB: seg_o = SEG_B;
      4'hC: seg_o = SEG_C;
      4'hD: seg_o = SEG_D;
      4'hE: seg_o = SEG_E;
      4'hF: seg_o = SEG_F;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/module_barrido_mux.sv
// Multiplexed scanner for N seven-segment digits with dead-time blanking,
// per-digit enable mask, 4-bit PWM brightness and frame-synchronous double
// buffering of the digit data.
//
// Ports:
//   clk          in  1                  system clock
//   rst          in  1                  asynchronous active-high reset
//   load         in  1                  capture digits_in into the shadow buffer
//   digits_in    in  N_DIGITS*DIGIT_W   digit codes, digit 0 in the LSBs
//   enable_mask  in  N_DIGITS           1 = digit takes part in the scan
//   brightness   in  4                  duty level, 0 = dark, 15 = full
//   col          out N_DIGITS           one-hot column drive
//   seg          out 7                  segments {g,f,e,d,c,b,a}
//   digit_idx    out $clog2(N_DIGITS)   index of the current slot
//   frame_done   out 1                  one-cycle pulse at each frame wrap
//
// Optional build macro: BARRIDO_LEADING_ZERO_BLANK_EN
//   When defined, leading zero digits (index > 0, code 0, every higher
//   enabled digit also 0) keep their column timing but show no segments.
module module_barrido_mux
  import barrido_pkg::*;
#(
  parameter int   N_DIGITS       = 4,
  parameter int   DIGIT_W        = 4,
  parameter int   WAIT_TIME      = 27000,
  parameter int   BLANK_TIME     = 270,
  parameter logic COL_ACTIVE_LOW = 1'b0,
  parameter logic SEG_ACTIVE_LOW = 1'b0,
  localparam int  IDX_W          = $clog2(N_DIGITS)
)
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [N_DIGITS*DIGIT_W-1:0]   digits_in,
  input  logic [N_DIGITS-1:0]           enable_mask,
  input  logic [3:0]                    brightness,
  output logic [N_DIGITS-1:0]           col,
  output logic [6:0]                    seg,
  output logic [IDX_W-1:0]              digit_idx,
  output logic                          frame_done
);

  localparam int SLOT_W  = (WAIT_TIME > 1) ? $clog2(WAIT_TIME) : 1;
  localparam int BLANK_W = (BLANK_TIME > 1) ? $clog2(BLANK_TIME) : 1;
  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(WAIT_TIME - 1);
  localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_TIME - 1);
  localparam logic [3:0]         PWM_LAST   = 4'(PWM_PERIOD - 1);

  scan_state_t                   state_q, state_d;
  logic [BLANK_W-1:0]            blankCnt_q, blankCnt_d;
  logic [SLOT_W-1:0]             slotCnt_q, slotCnt_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [N_DIGITS*DIGIT_W-1:0]   shadow_q;
  logic [N_DIGITS*DIGIT_W-1:0]   active_q, active_d;
  logic                          frameDone_q, frameDone_d;
  logic [3:0]                    pwmCnt_q;
  logic [N_DIGITS-1:0]           col_q, col_d;
  logic [6:0]                    seg_q, seg_d;
  logic [IDX_W-1:0]              idxOut_q;

  logic                          maskAny;
  logic                          blankDone;
  logic [IDX_W-1:0]              nextIdx;
  logic [IDX_W-1:0]              lowIdx;
  logic [IDX_W-1:0]              afterIdx;
  logic                          afterFound;
  logic                          wrap;
  logic [DIGIT_W-1:0]            curCode;
  logic [6:0]                    decSeg;
  logic                          colOn;
  logic                          suppress;

  assign maskAny   = |enable_mask;
  assign blankDone = (BLANK_TIME == 0) || (blankCnt_q == BLANK_LAST);

  // Circular search for the next enabled digit. Scanning from the top down
  // leaves the lowest enabled index overall in lowIdx and the lowest enabled
  // index above the current one in afterIdx. Having nothing above the
  // current slot means the scan wraps, which is the frame boundary.
  always_comb begin
    lowIdx     = '0;
    afterIdx   = '0;
    afterFound = 1'b0;
    for (int j = N_DIGITS - 1; j >= 0; j--) begin
      if (enable_mask[j]) begin
        lowIdx = IDX_W'(j);
        if (IDX_W'(j) > idx_q) begin
          afterIdx   = IDX_W'(j);
          afterFound = 1'b1;
        end
      end
    end
    nextIdx = afterFound ? afterIdx : lowIdx;
    wrap    = !afterFound;
  end

  // Code of the digit currently being scanned, taken from the active buffer.
  always_comb begin
    curCode = '0;
    for (int j = 0; j < N_DIGITS; j++) begin
      if (IDX_W'(j) == idx_q) begin
        curCode = active_q[j*DIGIT_W +: DIGIT_W];
      end
    end
  end

`ifdef BARRIDO_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it is zero and every enabled digit above
  // it is zero as well; digit 0 is never suppressed so "0" stays visible.
  always_comb begin
    logic higherZero;
    higherZero = 1'b1;
    for (int j = 0; j < N_DIGITS; j++) begin
      if ((IDX_W'(j) > idx_q) && enable_mask[j] &&
          (active_q[j*DIGIT_W +: DIGIT_W] != '0)) begin
        higherZero = 1'b0;
      end
    end
    suppress = (idx_q != '0) && (curCode == '0) && higherZero;
  end
`else
  assign suppress = 1'b0;
`endif

  module_hex_to_7seg u_hex_to_7seg (
    .code_i (4'(curCode)),
    .seg_o  (decSeg)
  );

  // Scan FSM: BLANK holds the columns dark for BLANK_TIME cycles, ON lights
  // the selected digit for WAIT_TIME cycles and then advances the index. The
  // active buffer only changes on a wrap so a frame never shows mixed data.
  always_comb begin
    state_d     = state_q;
    blankCnt_d  = blankCnt_q;
    slotCnt_d   = slotCnt_q;
    idx_d       = idx_q;
    active_d    = active_q;
    frameDone_d = 1'b0;
    unique case (state_q)
      BLANK: begin
        if (!maskAny) begin
          blankCnt_d = '0;
        end else if (blankDone) begin
          blankCnt_d = '0;
          slotCnt_d  = '0;
          state_d    = ON;
          if (!enable_mask[idx_q]) begin
            idx_d = lowIdx;
          end
        end else begin
          blankCnt_d = blankCnt_q + 1'b1;
        end
      end
      ON: begin
        if (slotCnt_q == SLOT_LAST) begin
          slotCnt_d = '0;
          state_d   = ((BLANK_TIME == 0) && maskAny) ? ON : BLANK;
          if (maskAny) begin
            idx_d = nextIdx;
            if (wrap) begin
              active_d    = shadow_q;
              frameDone_d = 1'b1;
            end
          end
        end else begin
          slotCnt_d = slotCnt_q + 1'b1;
        end
      end
      default: state_d = BLANK;
    endcase
  end

  // Column is lit only while ON, still enabled, and inside the PWM window.
  // Segments follow the column so nothing glows on a dark column.
  always_comb begin
    colOn = (state_q == ON) && enable_mask[idx_q] && (pwmCnt_q < brightness);
    col_d = colOn ? (N_DIGITS'(1) << idx_q) : '0;
    seg_d = (colOn && !suppress) ? decSeg : SEG_OFF;
  end

  // All state, counters, buffers and the registered pin drive. The output
  // registers reset to the dark level so the pins blank the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BLANK;
      blankCnt_q  <= '0;
      slotCnt_q   <= '0;
      idx_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      frameDone_q <= 1'b0;
      pwmCnt_q    <= '0;
      col_q       <= '0;
      seg_q       <= SEG_OFF;
      idxOut_q    <= '0;
    end else begin
      state_q     <= state_d;
      blankCnt_q  <= blankCnt_d;
      slotCnt_q   <= slotCnt_d;
      idx_q       <= idx_d;
      active_q    <= active_d;
      frameDone_q <= frameDone_d;
      pwmCnt_q    <= (pwmCnt_q == PWM_LAST) ? 4'd0 : pwmCnt_q + 4'd1;
      col_q       <= col_d;
      seg_q       <= seg_d;
      idxOut_q    <= idx_q;
      if (load) begin
        shadow_q <= digits_in;
      end
    end
  end

  assign col        = col_q ^ {N_DIGITS{COL_ACTIVE_LOW}};
  assign seg        = seg_q ^ {7{SEG_ACTIVE_LOW}};
  assign digit_idx  = idxOut_q;
  assign frame_done = frameDone_q;

endmodule

// File: tb/tb_module_barrido_mux.sv
// Self-checking bench for module_barrido_mux (4 digits, 8-cycle slots,
// 2-cycle dead time, active-high pins). Expected pin values come from a
// slot/frame arithmetic model of the scan schedule.
module tb_module_barrido_mux;

  localparam int N    = 4;
  localparam int WT   = 8;
  localparam int BT   = 2;
  localparam int SLOT = WT + BT;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = '0;
  logic [3:0]  enable_mask = '0;
  logic [3:0]  brightness = 4'd15;
  logic [3:0]  col;
  logic [6:0]  seg;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int checks = 0;
  int passes = 0;

  module_barrido_mux #(
    .N_DIGITS       (N),
    .DIGIT_W        (4),
    .WAIT_TIME      (WT),
    .BLANK_TIME     (BT),
    .COL_ACTIVE_LOW (1'b0),
    .SEG_ACTIVE_LOW (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .digits_in   (digits_in),
    .enable_mask (enable_mask),
    .brightness  (brightness),
    .col         (col),
    .seg         (seg),
    .digit_idx   (digit_idx),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Watchdog so a stuck run still ends with a visible failure.
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reset the DUT with the given mask/brightness and release it on a falling
  // edge, so the caller starts at state cycle 0.
  task automatic applyStimulus(input logic [3:0] m, input logic [3:0] br);
    @(negedge clk);
    rst = 1'b1;
    load = 1'b0;
    digits_in = '0;
    enable_mask = m;
    brightness = br;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int enabledCount(input logic [3:0] m);
    int c = 0;
    for (int i = 0; i < N; i++) if (m[i]) c++;
    return c;
  endfunction

  function automatic int enabledNth(input logic [3:0] m, input int n);
    int c = 0;
    for (int i = 0; i < N; i++) begin
      if (m[i]) begin
        if (c == n) return i;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic logic [6:0] glyphFor(input logic [15:0] data, input logic [3:0] m, input int d);
    logic [3:0] code;
    code = data[d*4 +: 4];
`ifdef BARRIDO_LEADING_ZERO_BLANK_EN
    if (d > 0 && code == 4'h0) begin
      logic lead = 1'b1;
      for (int j = d + 1; j < N; j++) if (m[j] && data[j*4 +: 4] != 4'h0) lead = 1'b0;
      if (lead) return 7'h00;
    end
`endif
    return GLYPH[code];
  endfunction

  // Schedule model: state cycle k belongs to slot k/SLOT, the first BT cycles
  // of a slot are dark, slot s shows the (s mod count)-th enabled digit, the
  // PWM phase is k mod 15, and each frame shows the shadow data captured at
  // the previous frame's last cycle. Pins show state cycle k during k+1.
  task automatic runModel(input logic [3:0] m, input logic [3:0] br,
                          input logic [15:0] v1, input int at1,
                          input logic [15:0] v2, input int at2, input int cycles);
    logic [15:0] shadowM = '0;
    logic [15:0] activeM = '0;
    logic [3:0]  eCol = '0;
    logic [6:0]  eSeg = '0;
    logic [1:0]  eIdx = '0;
    logic        eFd = 1'b0;
    int cnt, s, pos, d;
    logic on;
    cnt = enabledCount(m);
    for (int k = 0; k < cycles; k++) begin
      checkOutput($sformatf("col@%0d", k), 32'(col), 32'(eCol));
      checkOutput($sformatf("seg@%0d", k), 32'(seg), 32'(eSeg));
      checkOutput($sformatf("idx@%0d", k), 32'(digit_idx), 32'(eIdx));
      checkOutput($sformatf("frame_done@%0d", k), 32'(frame_done), 32'(eFd));
      s    = k / SLOT;
      pos  = k % SLOT;
      d    = enabledNth(m, s % cnt);
      on   = (pos >= BT) && ((k % 15) < int'(br));
      eCol = on ? 4'(1 << d) : 4'd0;
      eSeg = on ? glyphFor(activeM, m, d) : 7'h00;
      eIdx = (s == 0 && pos < BT) ? 2'd0 : 2'(d);
      eFd  = (pos == SLOT - 1) && ((s % cnt) == cnt - 1);
      load = (k == at1) || (k == at2);
      digits_in = (k == at2) ? v2 : v1;
      @(posedge clk);
      if (eFd) activeM = shadowM;
      if (load) shadowM = digits_in;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  task automatic waitCol(input string tag, input logic [3:0] target, input int budget);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (col === target) seen = 1'b1;
    end
    checkOutput(tag, 32'(seen), 32'd1);
  endtask

  initial begin
    logic [3:0] rm, rb;
    int rc;

    // Full scan: 1234 shown from frame 1, ABCD loaded mid-frame shown from frame 2.
    applyStimulus(4'b1111, 4'd15);
    runModel(4'b1111, 4'd15, 16'h1234, 0, 16'hABCD, 55, 130);

    // Load coincident with the frame boundary is deferred one frame.
    applyStimulus(4'b1111, 4'd15);
    runModel(4'b1111, 4'd15, 16'h1234, 0, 16'hABCD, 79, 170);

    // Sparse mask, then reduced and zero brightness.
    applyStimulus(4'b0101, 4'd15);
    runModel(4'b0101, 4'd15, 16'h1234, 0, 16'h0, -1, 90);
    applyStimulus(4'b1111, 4'd5);
    runModel(4'b1111, 4'd5, 16'h1234, 0, 16'h0, -1, 90);
    applyStimulus(4'b1111, 4'd0);
    runModel(4'b1111, 4'd0, 16'h1234, 0, 16'h0, -1, 90);

    // Leading-zero pattern (suppression depends on the build macro).
    applyStimulus(4'b1111, 4'd15);
    runModel(4'b1111, 4'd15, 16'h0050, 0, 16'h0, -1, 90);

    // Empty mask: dark and no frame pulses; enabling digit 2 lights it.
    applyStimulus(4'b0000, 4'd15);
    for (int i = 0; i < 60; i++) begin
      checkOutput($sformatf("mask0_col@%0d", i), 32'(col), 32'd0);
      checkOutput($sformatf("mask0_fd@%0d", i), 32'(frame_done), 32'd0);
      @(negedge clk);
    end
    enable_mask = 4'b0100;
    waitCol("mask_enable_col", 4'b0100, 40);
    checkOutput("mask_enable_idx", 32'(digit_idx), 32'd2);

    // Disabling the lit digit darkens its column on the next cycle.
    applyStimulus(4'b1111, 4'd15);
    waitCol("wait_digit1", 4'b0010, 60);
    enable_mask = 4'b1101;
    @(negedge clk);
    checkOutput("disable_midslot_col", 32'(col), 32'd0);
    checkOutput("disable_midslot_seg", 32'(seg), 32'd0);

    // Asynchronous reset during digit 2 blanks the pins before the next edge,
    // then the scan restarts at digit 0 with zeroed buffers.
    applyStimulus(4'b1111, 4'd15);
    waitCol("wait_digit2", 4'b0100, 60);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_col", 32'(col), 32'd0);
    checkOutput("async_rst_seg", 32'(seg), 32'd0);
    checkOutput("async_rst_idx", 32'(digit_idx), 32'd0);
    checkOutput("async_rst_fd", 32'(frame_done), 32'd0);
    applyStimulus(4'b1111, 4'd15);
    runModel(4'b1111, 4'd15, 16'h0, -1, 16'h0, -1, 90);

    // Randomised configurations with a random second load inside frame 1.
    for (int r = 0; r < 6; r++) begin
      rm = 4'($urandom_range(15, 1));
      rb = 4'($urandom_range(15, 0));
      rc = enabledCount(rm);
      applyStimulus(rm, rb);
      runModel(rm, rb, 16'($urandom), 0, 16'($urandom),
               int'($urandom_range(2*rc*SLOT - 1, rc*SLOT)), 3*rc*SLOT + 3);
    end

    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
